// File: rtl/key_token_parser_if.sv
// Bundle of the key-token input stream and the ALU request stream
// for key_token_parser. The slave modport is the parser's view; the master
// modport is the view of whatever drives tokens and plays the ALU role.
interface key_token_parser_if #(
  parameter int WIDTH = 16
);
  logic [4:0]       i_data;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] o_a;
  logic [WIDTH-1:0] o_b;
  logic [1:0]       o_op;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_entry;
  logic             o_overflow;

  modport slave (
    input  i_data, i_valid, i_ready,
    output o_ready, o_a, o_b, o_op, o_valid, o_entry, o_overflow
  );

  modport master (
    output i_data, i_valid, i_ready,
    input  o_ready, o_a, o_b, o_op, o_valid, o_entry, o_overflow
  );
endinterface

// File: rtl/key_token_parser.sv
// key_token_parser: consumes keypad tokens, builds two decimal operands in
// binary, latches the operator and issues one {A, B, op} request to the ALU
// when equals is pressed.
// Optional macro INPUT_OVF_STICKY_EN: when defined, the overflow flag holds
// until AC or reset; otherwise it is a one-cycle pulse after a rejected digit.
module key_token_parser #(
  parameter int WIDTH = 16
) (
  input logic              clk,
  input logic              rst_n,
  key_token_parser_if.slave bus
);

  typedef enum logic [1:0] {S_A, S_OP, S_B, S_ISSUE} state_t;

  localparam logic [4:0] TOK_AC  = 5'd16;
  localparam logic [4:0] TOK_ADD = 5'd17;
  localparam logic [4:0] TOK_DIV = 5'd20;
  localparam logic [4:0] TOK_EQ  = 5'd21;

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             valid;
  logic             ready;
  logic             ovf;

  logic             accept;
  logic             handshake;
  logic             is_digit;
  logic             is_op;
  logic [3:0]       digit_val;
  logic [WIDTH+3:0] a_next;
  logic [WIDTH+3:0] b_next;
  logic             a_fits;
  logic             b_fits;

  // Token decode and the x10+d accumulation with four guard bits for overflow
  always_comb begin
    accept    = bus.i_valid && ready;
    handshake = valid && bus.i_ready;
    is_digit  = (bus.i_data <= 5'd9);
    is_op     = (bus.i_data >= TOK_ADD) && (bus.i_data <= TOK_DIV);
    digit_val = bus.i_data[3:0];
    a_next    = ({4'b0000, a} << 3) + ({4'b0000, a} << 1) + {{WIDTH{1'b0}}, digit_val};
    b_next    = ({4'b0000, b} << 3) + ({4'b0000, b} << 1) + {{WIDTH{1'b0}}, digit_val};
    a_fits    = (a_next[WIDTH+3:WIDTH] == 4'd0);
    b_fits    = (b_next[WIDTH+3:WIDTH] == 4'd0);
  end

  // Entry state machine with registered handshake outputs and operand registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_A;
      a     <= '0;
      b     <= '0;
      op    <= 2'd0;
      valid <= 1'b0;
      ready <= 1'b1;
      ovf   <= 1'b0;
    end else begin
`ifndef INPUT_OVF_STICKY_EN
      ovf <= 1'b0;
`endif
      case (state)
        S_ISSUE: begin
          if (handshake) begin
            a     <= '0;
            b     <= '0;
            valid <= 1'b0;
            ready <= 1'b1;
            state <= S_A;
          end
        end
        default: begin
          if (accept) begin
            if (bus.i_data == TOK_AC) begin
              a     <= '0;
              b     <= '0;
              op    <= 2'd0;
              ovf   <= 1'b0;
              state <= S_A;
            end else if (is_digit) begin
              case (state)
                S_A: begin
                  if (a_fits) a <= a_next[WIDTH-1:0];
                  else        ovf <= 1'b1;
                end
                S_OP: begin
                  b     <= {{(WIDTH-4){1'b0}}, digit_val};
                  state <= S_B;
                end
                S_B: begin
                  if (b_fits) b <= b_next[WIDTH-1:0];
                  else        ovf <= 1'b1;
                end
                default: ;
              endcase
            end else if (is_op) begin
              if (state == S_A || state == S_OP) begin
                op    <= bus.i_data[1:0] - 2'd1;
                state <= S_OP;
              end
            end else if (bus.i_data == TOK_EQ) begin
              if (state == S_B) begin
                valid <= 1'b1;
                ready <= 1'b0;
                state <= S_ISSUE;
              end
            end
          end
        end
      endcase
    end
  end

  assign bus.o_ready    = ready;
  assign bus.o_valid    = valid;
  assign bus.o_a        = a;
  assign bus.o_b        = b;
  assign bus.o_op       = op;
  assign bus.o_overflow = ovf;
  assign bus.o_entry    = (state == S_A || state == S_OP) ? a : b;

endmodule

// File: tb/tb_key_token_parser.sv
// Self-checking bench for key_token_parser: directed calculator sequences
// followed by randomized token/ready traffic, all checked cycle by cycle
// against a behavioural calculator model.
module tb_key_token_parser;
  localparam int WIDTH = 16;
  localparam longint LIMIT = (64'd1 << WIDTH) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Free-running clock
  always #5 clk = ~clk;

  key_token_parser_if #(.WIDTH(WIDTH)) bus ();

  key_token_parser #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int compared = 0;
  int mismatched = 0;

  // Calculator model: stage 0 typing A, 1 operator chosen, 2 typing B, 3 waiting on ALU
  longint ma, mb;
  int     mop;
  int     stage;
  bit     movf;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    ma = 0; mb = 0; mop = 0; stage = 0; movf = 0;
  endtask

  task automatic modelStep(input int data, input bit valid, input bit ready);
    bit rej;
    rej = 0;
    if (stage == 3) begin
      if (ready) begin
        ma = 0; mb = 0; stage = 0;
      end
    end else if (valid) begin
      if (data == 16) begin
        ma = 0; mb = 0; mop = 0; stage = 0; movf = 0;
      end else if (data <= 9) begin
        if (stage == 0) begin
          if (ma * 10 + data > LIMIT) rej = 1; else ma = ma * 10 + data;
        end else if (stage == 1) begin
          mb = data; stage = 2;
        end else begin
          if (mb * 10 + data > LIMIT) rej = 1; else mb = mb * 10 + data;
        end
      end else if (data >= 17 && data <= 20) begin
        if (stage <= 1) begin
          mop = data - 17; stage = 1;
        end
      end else if (data == 21) begin
        if (stage == 2) stage = 3;
      end
    end
`ifdef INPUT_OVF_STICKY_EN
    movf = movf | rej;
`else
    movf = rej;
`endif
  endtask

  // One clock of stimulus, model update and full output comparison
  task automatic applyStimulus(input int data, input bit valid, input bit ready);
    bus.i_data  = 5'(data);
    bus.i_valid = valid;
    bus.i_ready = ready;
    @(posedge clk);
    modelStep(data, valid, ready);
    #1;
    checkOutput("o_a", 64'(bus.o_a), 64'(ma));
    checkOutput("o_b", 64'(bus.o_b), 64'(mb));
    checkOutput("o_op", 64'(bus.o_op), 64'(mop));
    checkOutput("o_valid", 64'(bus.o_valid), 64'(stage == 3));
    checkOutput("o_ready", 64'(bus.o_ready), 64'(stage != 3));
    checkOutput("o_overflow", 64'(bus.o_overflow), 64'(movf));
    checkOutput("o_entry", 64'(bus.o_entry), 64'((stage >= 2) ? mb : ma));
  endtask

  task automatic idle(input bit ready);
    applyStimulus(0, 1'b0, ready);
  endtask

  int seqA[$];

  initial begin
    bus.i_data = '0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    modelReset();
    #12;
    checkOutput("rst_o_a", 64'(bus.o_a), 64'd0);
    checkOutput("rst_o_b", 64'(bus.o_b), 64'd0);
    checkOutput("rst_o_op", 64'(bus.o_op), 64'd0);
    checkOutput("rst_o_entry", 64'(bus.o_entry), 64'd0);
    checkOutput("rst_o_valid", 64'(bus.o_valid), 64'd0);
    checkOutput("rst_o_overflow", 64'(bus.o_overflow), 64'd0);
    checkOutput("rst_o_ready", 64'(bus.o_ready), 64'd1);
    rst_n = 1'b1;

    // 12 + 34 with the ALU always ready
    seqA = '{1, 2, 17, 3, 4, 21};
    foreach (seqA[i]) applyStimulus(seqA[i], 1'b1, 1'b1);
    checkOutput("t1_valid", 64'(bus.o_valid), 64'd1);
    checkOutput("t1_a", 64'(bus.o_a), 64'd12);
    checkOutput("t1_b", 64'(bus.o_b), 64'd34);
    checkOutput("t1_op", 64'(bus.o_op), 64'd0);
    idle(1'b1);
    checkOutput("t1_valid_drop", 64'(bus.o_valid), 64'd0);
    checkOutput("t1_a_clr", 64'(bus.o_a), 64'd0);
    checkOutput("t1_b_clr", 64'(bus.o_b), 64'd0);

    // Operator replaced, ALU stalls for five cycles
    seqA = '{9, 18, 19, 7, 21};
    foreach (seqA[i]) applyStimulus(seqA[i], 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(3, 1'b1, 1'b0);
      checkOutput("t2_valid", 64'(bus.o_valid), 64'd1);
      checkOutput("t2_ready", 64'(bus.o_ready), 64'd0);
      checkOutput("t2_a", 64'(bus.o_a), 64'd9);
      checkOutput("t2_b", 64'(bus.o_b), 64'd7);
      checkOutput("t2_op", 64'(bus.o_op), 64'd2);
    end
    idle(1'b1);
    checkOutput("t2_done", 64'(bus.o_valid), 64'd0);

    // Largest operand, then an overflowing digit
    seqA = '{16, 6, 5, 5, 3, 5};
    foreach (seqA[i]) applyStimulus(seqA[i], 1'b1, 1'b1);
    checkOutput("t3_max", 64'(bus.o_a), 64'd65535);
    applyStimulus(6, 1'b1, 1'b1);
    checkOutput("t3_hold", 64'(bus.o_a), 64'd65535);
    checkOutput("t3_ovf", 64'(bus.o_overflow), 64'd1);
    idle(1'b1);
`ifdef INPUT_OVF_STICKY_EN
    checkOutput("t3_ovf_after", 64'(bus.o_overflow), 64'd1);
`else
    checkOutput("t3_ovf_after", 64'(bus.o_overflow), 64'd0);
`endif
    applyStimulus(16, 1'b1, 1'b1);
    checkOutput("t3_ovf_ac", 64'(bus.o_overflow), 64'd0);

    // AC mid-expression, then EQ ignored in S_A
    seqA = '{5, 17, 16};
    foreach (seqA[i]) applyStimulus(seqA[i], 1'b1, 1'b1);
    checkOutput("t4_ac_a", 64'(bus.o_a), 64'd0);
    applyStimulus(21, 1'b1, 1'b1);
    checkOutput("t4_eq_ign", 64'(bus.o_valid), 64'd0);
    applyStimulus(3, 1'b1, 1'b1);
    checkOutput("t4_a", 64'(bus.o_a), 64'd3);

    // Ignored EQs and an unknown code
    seqA = '{16, 4, 21, 17, 22, 21};
    foreach (seqA[i]) begin
      applyStimulus(seqA[i], 1'b1, 1'b1);
      checkOutput("t5_no_req", 64'(bus.o_valid), 64'd0);
    end
    idle(1'b1);
    checkOutput("t5_no_req_end", 64'(bus.o_valid), 64'd0);

    // Randomized traffic
    applyStimulus(16, 1'b1, 1'b1);
    for (int n = 0; n < 3000; n++) begin
      int  sel;
      int  code;
      bit  v;
      bit  r;
      sel = int'($urandom_range(0, 99));
      if (sel < 55)      code = int'($urandom_range(0, 9));
      else if (sel < 75) code = int'($urandom_range(17, 20));
      else if (sel < 88) code = 21;
      else if (sel < 92) code = 16;
      else if (sel < 96) code = int'($urandom_range(10, 15));
      else               code = int'($urandom_range(22, 31));
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      applyStimulus(code, v, r);
    end

    // Asynchronous reset while a request is pending
    idle(1'b1);
    seqA = '{16, 1, 17, 2, 21};
    foreach (seqA[i]) applyStimulus(seqA[i], 1'b1, 1'b0);
    idle(1'b0);
    checkOutput("t6_pending", 64'(bus.o_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("t6_valid", 64'(bus.o_valid), 64'd0);
    checkOutput("t6_ready", 64'(bus.o_ready), 64'd1);
    checkOutput("t6_a", 64'(bus.o_a), 64'd0);
    checkOutput("t6_b", 64'(bus.o_b), 64'd0);
    #2;
    rst_n = 1'b1;
    seqA = '{8, 20, 2, 21};
    foreach (seqA[i]) applyStimulus(seqA[i], 1'b1, 1'b1);
    checkOutput("t6_op", 64'(bus.o_op), 64'd3);
    idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
